tristate_bus_ctrl: RTL



---
 rtl/tristate_bus_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tristate_bus_ctrl.sv
// rtl/tristate_bus_ctrl.sv - round-robin arbitrated multi-channel tristate bus driver with turnaround
// Optional readback contention check enabled by TRISTATE_BUS_READBACK_EN.
module tristate_bus_ctrl #(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int MAX_HOLD = 4,
  parameter int TURN_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*WIDTH-1:0] data_in,
  inout  wire  [WIDTH-1:0]     bus,
  output logic                 bus_oe,
  output logic [NCH-1:0]       grant,
  output logic [NCH-1:0]       ack,
  output logic                 busy
`ifdef TRISTATE_BUS_READBACK_EN
  ,
  output logic                 contention_err
`endif
);

  localparam int OW = $clog2(NCH);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
  localparam logic [OW-1:0] LAST_RST  = OW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  grant_q, grant_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_owner_q, last_owner_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]   turn_cnt_q, turn_cnt_d;

  logic            arb_hit;
  logic [OW-1:0]   arb_win;
  logic [NCH-1:0]  arb_onehot;
  logic            take_grant;
  logic            drive;
  logic [WIDTH-1:0] owner_word;

  // Search starts just past the previous owner so it drops to lowest priority.
  always_comb begin
    int cand;
    logic [OW-1:0] cand_idx;
    arb_hit  = 1'b0;
    arb_win  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = int'(last_owner_q) + k;
      if (cand >= NCH) cand = cand - NCH;
      cand_idx = OW'(cand);
      if (!arb_hit && req[cand_idx]) begin
        arb_hit = 1'b1;
        arb_win = cand_idx;
      end
    end
  end

  assign arb_onehot = NCH'(1) << arb_win;

  assign owner_word = data_in[int'(owner_q)*WIDTH +: WIDTH];
  assign drive      = (state_q == DRIVE) && req[owner_q];
  assign bus_oe     = drive;
  assign bus        = drive ? owner_word : {WIDTH{1'bz}};
  assign ack        = drive ? grant_q : '0;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    turn_cnt_d   = turn_cnt_q;
    take_grant   = 1'b0;
    case (state_q)
      IDLE: begin
        take_grant = arb_hit;
      end
      DRIVE: begin
        if (!req[owner_q] || hold_cnt_q == HOLD_LAST) begin
          state_d    = TURN;
          grant_d    = '0;
          turn_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          if (arb_hit) begin
            take_grant = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (take_grant) begin
      state_d      = DRIVE;
      grant_d      = arb_onehot;
      owner_d      = arb_win;
      last_owner_d = arb_win;
      hold_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      hold_cnt_q   <= '0;
      turn_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
    end
  end

`ifdef TRISTATE_BUS_READBACK_EN
  // Any X/Z on the readback is treated as contention, hence the case inequality.
  logic contention_q, contention_d;
  logic mismatch;

  assign mismatch       = drive && (bus !== owner_word);
  assign contention_d   = contention_q | mismatch;
  assign contention_err = contention_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) contention_q <= 1'b0;
    else     contention_q <= contention_d;
  end
`endif

endmodule
